// File: rtl/arb_rr_queue_pkg.sv
// arb_rr_queue_pkg: shared types, default parameters and helpers for the arb_rr_queue block.
//   DEF_*     default configuration (2 channels, 32-bit PA, 128-bit line, 4-bit ID, 4-deep queue)
//   id_t      transaction ID in the default configuration
//   arb_req_t queue entry layout {addr, data, write, id} in the default configuration
//   ptr_w()   pointer width for a power-of-2 queue depth
package arb_rr_queue_pkg;

    localparam int DEF_N_CH       = 2;
    localparam int DEF_PA_WIDTH   = 32;
    localparam int DEF_LINE_WIDTH = 128;
    localparam int DEF_ID_WIDTH   = 4;
    localparam int DEF_DEPTH      = 4;

    typedef logic [DEF_ID_WIDTH-1:0] id_t;

    typedef struct packed {
        logic [DEF_PA_WIDTH-1:0]   addr;
        logic [DEF_LINE_WIDTH-1:0] data;
        logic                      write;
        id_t                       id;
    } arb_req_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/arb_rr_queue_rr_arbiter.sv
// arb_rr_queue_rr_arbiter: one-hot grant among requesting channels.
//   clk, rst   clock and synchronous active-high reset (rotating pointer only)
//   req        per-channel request vector, already qualified by the caller
//   grant      one-hot grant, combinational from req
//   grant_idx  binary index of the granted channel
// Build option ARB_FIXED_PRIO_EN: lowest index always wins and no pointer exists.
// Default: round-robin, search starts at the channel after the last one granted.
module arb_rr_queue_rr_arbiter #(
    parameter int N_CH = 2,
    parameter int CW   = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    output logic [N_CH-1:0] grant,
    output logic [CW-1:0]   grant_idx
);

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_CH; i++)
            if (grant[i]) grant_idx = CW'(i);
    end

`ifdef ARB_FIXED_PRIO_EN

    logic unused_ok;

    assign grant     = req & (-req);
    assign unused_ok = ^{clk, rst};

`else

    logic [CW-1:0]     ptr;
    logic [2*N_CH-1:0] dbl_req, dbl_gnt;
    logic [N_CH-1:0]   rot, pick;

    // Rotate so the pointer channel sits at bit 0, take the lowest set bit, rotate back.
    assign dbl_req = {req, req} >> ptr;
    assign rot     = dbl_req[N_CH-1:0];
    assign pick    = rot & (-rot);
    assign dbl_gnt = {pick, pick} << ptr;
    assign grant   = dbl_gnt[2*N_CH-1:N_CH];

    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (|req) ptr <= (grant_idx == CW'(N_CH-1)) ? '0 : grant_idx + CW'(1);
    end

`endif

endmodule

// File: rtl/arb_rr_queue.sv
// arb_rr_queue: N_CH-channel request arbiter with in-order issue queue, ID allocation
// and read-response routing back to the issuing channel.
//   i_req_valid/addr/data/write  per-channel requests
//   o_req_ready, o_req_id        one-hot grant and the ID given to the granted request
//   o_mem_*                      queue head towards memory, i_mem_ack pops it
//   i_mem_enable/id/data         read response from memory, o_mem_ack consumes it
//   o_rsp_valid/id/data          response to the owning channel, i_rsp_ack per channel
//   o_spurious                   sticky flag: response for an ID that was not outstanding
// Build option ARB_FIXED_PRIO_EN (inside the arbiter): fixed priority instead of round-robin.
module arb_rr_queue
    import arb_rr_queue_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int PA_WIDTH   = DEF_PA_WIDTH,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_CH-1:0]                 i_req_valid,
    input  logic [N_CH-1:0][PA_WIDTH-1:0]   i_req_addr,
    input  logic [N_CH-1:0][LINE_WIDTH-1:0] i_req_data,
    input  logic [N_CH-1:0]                 i_req_write,
    output logic [N_CH-1:0]                 o_req_ready,
    output logic [ID_WIDTH-1:0]             o_req_id,
    output logic                            o_mem_enable,
    output logic [PA_WIDTH-1:0]             o_mem_addr,
    output logic [LINE_WIDTH-1:0]           o_mem_data,
    output logic                            o_mem_write,
    output logic [ID_WIDTH-1:0]             o_mem_id,
    input  logic                            i_mem_ack,
    input  logic                            i_mem_enable,
    input  logic [ID_WIDTH-1:0]             i_mem_id,
    input  logic [LINE_WIDTH-1:0]           i_mem_data,
    output logic                            o_mem_ack,
    output logic [N_CH-1:0]                 o_rsp_valid,
    output logic [ID_WIDTH-1:0]             o_rsp_id,
    output logic [LINE_WIDTH-1:0]           o_rsp_data,
    input  logic [N_CH-1:0]                 i_rsp_ack,
    output logic                            o_spurious
);

    localparam int PW   = ptr_w(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CW   = $clog2(N_CH);
    localparam int N_ID = 2 ** ID_WIDTH;

    typedef struct packed {
        logic [PA_WIDTH-1:0]   addr;
        logic [LINE_WIDTH-1:0] data;
        logic                  write;
        logic [ID_WIDTH-1:0]   id;
    } req_t;

    req_t                q [DEPTH];
    req_t                head, in_req;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CNTW-1:0]     count;
    logic [ID_WIDTH-1:0] id_cnt;
    logic [N_ID-1:0]     outstanding, clr, set;
    logic [CW-1:0]       owner [N_ID];
    logic [N_CH-1:0]     arb_req, grant;
    logic [CW-1:0]       gidx, rsp_owner;
    logic                can_accept, push, pop, mem_en, rsp_en, rsp_hit, rsp_done;

    // An ID is only reused once its previous transaction has fully retired.
    assign can_accept = !rst && count != CNTW'(DEPTH) && !outstanding[id_cnt];
    assign arb_req    = can_accept ? i_req_valid : '0;

    arb_rr_queue_rr_arbiter #(.N_CH(N_CH)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (arb_req),
        .grant    (grant),
        .grant_idx(gidx)
    );

    assign push        = |grant;
    assign o_req_ready = grant;
    assign o_req_id    = rst ? '0 : id_cnt;
    assign in_req      = '{addr: i_req_addr[gidx], data: i_req_data[gidx], write: i_req_write[gidx], id: id_cnt};

    assign head         = q[rd_ptr];
    assign mem_en       = !rst && count != '0;
    assign pop          = mem_en && i_mem_ack;
    assign o_mem_enable = mem_en;
    assign o_mem_addr   = mem_en ? head.addr : '0;
    assign o_mem_data   = mem_en ? head.data : '0;
    assign o_mem_write  = mem_en && head.write;
    assign o_mem_id     = mem_en ? head.id : '0;

    assign rsp_owner   = owner[i_mem_id];
    assign rsp_en      = !rst && i_mem_enable;
    assign rsp_hit     = rsp_en && outstanding[i_mem_id];
    assign rsp_done    = rsp_hit && i_rsp_ack[rsp_owner];
    assign o_rsp_valid = rsp_hit ? N_CH'(1) << rsp_owner : '0;
    // Unknown IDs are acknowledged immediately so memory never stalls on them.
    assign o_mem_ack   = rsp_hit ? i_rsp_ack[rsp_owner] : rsp_en;
    assign o_rsp_id    = rsp_en ? i_mem_id : '0;
    assign o_rsp_data  = rsp_en ? i_mem_data : '0;

    // Writes retire at issue, reads at the acknowledged response; both may hit in one cycle.
    assign clr = ((pop && head.write) ? N_ID'(1) << head.id : '0) | (rsp_done ? N_ID'(1) << i_mem_id : '0);
    assign set = push ? N_ID'(1) << id_cnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            id_cnt      <= '0;
            outstanding <= '0;
            o_spurious  <= 1'b0;
        end else begin
            if (push) begin
                q[wr_ptr]     <= in_req;
                owner[id_cnt] <= gidx;
                wr_ptr        <= wr_ptr + PW'(1);
                id_cnt        <= id_cnt + ID_WIDTH'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop) count <= count + CNTW'(1);
            else if (!push && pop) count <= count - CNTW'(1);
            outstanding <= (outstanding & ~clr) | set;
            if (rsp_en && !outstanding[i_mem_id]) o_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_arb_rr_queue.sv
// tb_arb_rr_queue: scoreboard bench for arb_rr_queue (default round-robin build).
module tb_arb_rr_queue;

    localparam int N_CH  = 2;
    localparam int PA    = 32;
    localparam int LW    = 128;
    localparam int IW    = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [PA-1:0] addr;
        logic [LW-1:0] data;
        logic          write;
        logic [IW-1:0] id;
    } ent_t;

    typedef struct packed {
        logic [IW-1:0]   id;
        logic [N_CH-1:0] ch;
    } rsp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_CH-1:0]         i_req_valid, i_req_write, o_req_ready, o_rsp_valid, i_rsp_ack;
    logic [N_CH-1:0][PA-1:0] i_req_addr;
    logic [N_CH-1:0][LW-1:0] i_req_data;
    logic [IW-1:0]           o_req_id, o_mem_id, i_mem_id, o_rsp_id;
    logic                    o_mem_enable, o_mem_write, i_mem_ack, i_mem_enable, o_mem_ack, o_spurious;
    logic [PA-1:0]           o_mem_addr;
    logic [LW-1:0]           o_mem_data, i_mem_data, o_rsp_data;

    int              checks = 0;
    int              fails  = 0;
    ent_t            mem_q[$];
    rsp_t            rsp_q[$];
    logic [IW-1:0]   exp_id;
    logic [N_CH-1:0] exp_own [16];

    arb_rr_queue #(.N_CH(N_CH), .PA_WIDTH(PA), .LINE_WIDTH(LW), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_req_write(i_req_write),
        .o_req_ready(o_req_ready), .o_req_id(o_req_id),
        .o_mem_enable(o_mem_enable), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
        .o_mem_write(o_mem_write), .o_mem_id(o_mem_id), .i_mem_ack(i_mem_ack),
        .i_mem_enable(i_mem_enable), .i_mem_id(i_mem_id), .i_mem_data(i_mem_data), .o_mem_ack(o_mem_ack),
        .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_data(o_rsp_data),
        .i_rsp_ack(i_rsp_ack), .o_spurious(o_spurious)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] line(input int n);
        return {4{32'hC0DE_0000 ^ 32'(n)}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_req_valid  = '0;
        i_req_write  = '0;
        i_req_addr   = '0;
        i_req_data   = '0;
        i_mem_ack    = 1'b0;
        i_mem_enable = 1'b0;
        i_mem_id     = '0;
        i_mem_data   = '0;
        i_rsp_ack    = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_id = '0;
        mem_q.delete();
        rsp_q.delete();
    endtask

    // Record an accepted request in the scoreboard using the bench's expected grant.
    task automatic expect_accept(input logic [N_CH-1:0] g, input int ch);
        mem_q.push_back('{addr: i_req_addr[ch], data: i_req_data[ch], write: i_req_write[ch], id: exp_id});
        exp_own[exp_id] = g;
        exp_id = exp_id + 1'b1;
    endtask

    task automatic test_reset();
        ent_t e;
        idle();
        rst = 1'b1;
        i_req_valid  = 2'b11;
        i_mem_enable = 1'b1;
        i_mem_id     = 4'd7;
        step();
        step();
        checks++;
        if (o_req_ready !== 2'b00 || o_mem_enable !== 1'b0 || o_mem_ack !== 1'b0 || o_rsp_valid !== 2'b00 || o_spurious !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: ready=%b men=%b mack=%b rspv=%b spur=%b, required all zero",
                     o_req_ready, o_mem_enable, o_mem_ack, o_rsp_valid, o_spurious);
        end
        idle();
        rst = 1'b0;
        exp_id = '0;
        i_req_valid   = 2'b01;
        i_req_addr[0] = 32'h100;
        i_req_data[0] = line(1);
        #1;
        checks++;
        if (o_req_ready !== 2'b01 || o_req_id !== 4'd0) begin
            fails++;
            $display("FAIL first_grant: ready=%b id=%0d, required 01 id 0", o_req_ready, o_req_id);
        end
        expect_accept(2'b01, 0);
        step();
        i_req_valid = '0;
        #1;
        e = mem_q.pop_front();
        checks++;
        if (o_mem_enable !== 1'b1 || {o_mem_addr, o_mem_data, o_mem_write, o_mem_id} !== e) begin
            fails++;
            $display("FAIL first_issue: en=%b addr=%h id=%0d, required en 1 addr %h id %0d",
                     o_mem_enable, o_mem_addr, o_mem_id, e.addr, e.id);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (o_mem_enable !== 1'b0 || o_mem_addr !== '0) begin
            fails++;
            $display("FAIL reset_midop_held: en=%b addr=%h, required 0", o_mem_enable, o_mem_addr);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (o_mem_enable !== 1'b0) begin
            fails++;
            $display("FAIL reset_midop_drop: en=%b, required 0", o_mem_enable);
        end
    endtask

    task automatic test_rr_fill();
        logic [N_CH-1:0] g;
        do_reset();
        i_req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            g = (i % 2 == 0) ? 2'b01 : 2'b10;
            i_req_addr[0] = 32'h200 + 32'(i * 16);
            i_req_addr[1] = 32'h300 + 32'(i * 16);
            i_req_data[0] = line(10 + i);
            i_req_data[1] = line(20 + i);
            #1;
            checks++;
            if (o_req_ready !== g || o_req_id !== exp_id) begin
                fails++;
                $display("FAIL rr_grant[%0d]: ready=%b id=%0d, required %b id %0d", i, o_req_ready, o_req_id, g, exp_id);
            end
            expect_accept(g, i % 2);
            step();
        end
        checks++;
        if (o_req_ready !== 2'b00) begin
            fails++;
            $display("FAIL full_block: ready=%b, required 00", o_req_ready);
        end
    endtask

    task automatic test_full_pop();
        ent_t e;
        i_req_valid   = 2'b01;
        i_req_addr[0] = 32'h500;
        i_req_data[0] = line(50);
        i_mem_ack     = 1'b1;
        #1;
        checks++;
        if (o_req_ready !== 2'b00) begin
            fails++;
            $display("FAIL full_with_pop: ready=%b, required 00", o_req_ready);
        end
        e = mem_q.pop_front();
        checks++;
        if (o_mem_enable !== 1'b1 || {o_mem_addr, o_mem_data, o_mem_write, o_mem_id} !== e) begin
            fails++;
            $display("FAIL full_head: addr=%h id=%0d, required %h id %0d", o_mem_addr, o_mem_id, e.addr, e.id);
        end
        rsp_q.push_back('{id: e.id, ch: exp_own[e.id]});
        step();
        i_mem_ack = 1'b0;
        #1;
        checks++;
        if (o_req_ready !== 2'b01 || o_req_id !== exp_id) begin
            fails++;
            $display("FAIL after_pop_accept: ready=%b id=%0d, required 01 id %0d", o_req_ready, o_req_id, exp_id);
        end
        expect_accept(2'b01, 0);
        step();
        i_req_valid = '0;
    endtask

    task automatic test_response();
        ent_t e;
        rsp_t r;
        for (int k = 0; k < 8 && mem_q.size() > 0; k++) begin
            e = mem_q.pop_front();
            #1;
            checks++;
            if (o_mem_enable !== 1'b1 || {o_mem_addr, o_mem_data, o_mem_write, o_mem_id} !== e) begin
                fails++;
                $display("FAIL drain_head[%0d]: en=%b addr=%h id=%0d, required addr %h id %0d",
                         k, o_mem_enable, o_mem_addr, o_mem_id, e.addr, e.id);
            end
            if (!e.write) rsp_q.push_back('{id: e.id, ch: exp_own[e.id]});
            i_mem_ack = 1'b1;
            step();
            i_mem_ack = 1'b0;
        end
        #1;
        checks++;
        if (o_mem_enable !== 1'b0) begin
            fails++;
            $display("FAIL drained_empty: en=%b, required 0", o_mem_enable);
        end
        for (int k = 0; k < 8 && rsp_q.size() > 0; k++) begin
            r = rsp_q.pop_front();
            i_mem_enable = 1'b1;
            i_mem_id     = r.id;
            i_mem_data   = line(100 + k);
            i_rsp_ack    = '0;
            #1;
            checks++;
            if (o_rsp_valid !== r.ch || o_rsp_id !== r.id || o_rsp_data !== line(100 + k) || o_mem_ack !== 1'b0) begin
                fails++;
                $display("FAIL rsp_route id %0d: valid=%b rid=%0d mack=%b, required valid %b rid %0d mack 0",
                         r.id, o_rsp_valid, o_rsp_id, o_mem_ack, r.ch, r.id);
            end
            i_rsp_ack = r.ch;
            #1;
            checks++;
            if (o_mem_ack !== 1'b1) begin
                fails++;
                $display("FAIL rsp_ack id %0d: mack=%b, required 1", r.id, o_mem_ack);
            end
            step();
        end
        idle();
        #1;
        checks++;
        if (o_spurious !== 1'b0) begin
            fails++;
            $display("FAIL no_spurious: spur=%b, required 0", o_spurious);
        end
        i_mem_enable = 1'b1;
        i_mem_id     = 4'd3;
        #1;
        checks++;
        if (o_rsp_valid !== 2'b00 || o_mem_ack !== 1'b1) begin
            fails++;
            $display("FAIL id3_freed: valid=%b mack=%b, required 00 and 1", o_rsp_valid, o_mem_ack);
        end
        step();
        i_mem_enable = 1'b0;
        #1;
        checks++;
        if (o_spurious !== 1'b1) begin
            fails++;
            $display("FAIL id3_spurious: spur=%b, required 1", o_spurious);
        end
    endtask

    task automatic test_id_exhaust();
        ent_t e;
        rsp_t r;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            i_req_valid   = 2'b01;
            i_req_addr[0] = 32'h1000 + 32'(i * 64);
            i_req_data[0] = line(200 + i);
            #1;
            checks++;
            if (o_req_ready !== 2'b01 || o_req_id !== exp_id) begin
                fails++;
                $display("FAIL exhaust_grant[%0d]: ready=%b id=%0d, required 01 id %0d", i, o_req_ready, o_req_id, exp_id);
            end
            expect_accept(2'b01, 0);
            step();
            i_req_valid = '0;
            i_mem_ack   = 1'b1;
            e = mem_q.pop_front();
            #1;
            checks++;
            if (o_mem_enable !== 1'b1 || {o_mem_addr, o_mem_data, o_mem_write, o_mem_id} !== e) begin
                fails++;
                $display("FAIL exhaust_issue[%0d]: addr=%h id=%0d, required %h id %0d", i, o_mem_addr, o_mem_id, e.addr, e.id);
            end
            rsp_q.push_back('{id: e.id, ch: exp_own[e.id]});
            step();
            i_mem_ack = 1'b0;
        end
        i_req_valid = 2'b11;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (o_req_ready !== 2'b00) begin
                fails++;
                $display("FAIL ids_exhausted[%0d]: ready=%b, required 00", c, o_req_ready);
            end
            step();
        end
        r = rsp_q.pop_front();
        i_mem_enable = 1'b1;
        i_mem_id     = r.id;
        i_mem_data   = line(300);
        i_rsp_ack    = r.ch;
        #1;
        checks++;
        if (o_rsp_valid !== 2'b01 || o_mem_ack !== 1'b1 || r.id !== 4'd0) begin
            fails++;
            $display("FAIL id0_response: valid=%b mack=%b, required 01 and 1", o_rsp_valid, o_mem_ack);
        end
        step();
        i_mem_enable = 1'b0;
        i_rsp_ack    = '0;
        #1;
        checks++;
        if (o_req_ready !== 2'b10 || o_req_id !== 4'd0) begin
            fails++;
            $display("FAIL id0_reuse: ready=%b id=%0d, required 10 id 0", o_req_ready, o_req_id);
        end
        step();
        idle();
    endtask

    task automatic test_write_pop();
        ent_t e;
        do_reset();
        i_req_valid   = 2'b10;
        i_req_write   = 2'b10;
        i_req_addr[1] = 32'h700;
        i_req_data[1] = line(70);
        #1;
        checks++;
        if (o_req_ready !== 2'b10 || o_req_id !== 4'd0) begin
            fails++;
            $display("FAIL write_grant: ready=%b id=%0d, required 10 id 0", o_req_ready, o_req_id);
        end
        expect_accept(2'b10, 1);
        step();
        i_req_valid = '0;
        i_mem_ack   = 1'b1;
        e = mem_q.pop_front();
        #1;
        checks++;
        if (o_mem_enable !== 1'b1 || {o_mem_addr, o_mem_data, o_mem_write, o_mem_id} !== e) begin
            fails++;
            $display("FAIL write_head: addr=%h wr=%b id=%0d, required %h wr 1 id %0d", o_mem_addr, o_mem_write, o_mem_id, e.addr, e.id);
        end
        step();
        i_mem_ack    = 1'b0;
        i_mem_enable = 1'b1;
        i_mem_id     = 4'd0;
        #1;
        checks++;
        if (o_rsp_valid !== 2'b00 || o_mem_ack !== 1'b1) begin
            fails++;
            $display("FAIL write_retired: valid=%b mack=%b, required 00 and 1", o_rsp_valid, o_mem_ack);
        end
        step();
        i_mem_enable = 1'b0;
    endtask

    task automatic test_spurious();
        do_reset();
        #1;
        checks++;
        if (o_spurious !== 1'b0) begin
            fails++;
            $display("FAIL spur_clear: spur=%b, required 0", o_spurious);
        end
        i_mem_enable = 1'b1;
        i_mem_id     = 4'd7;
        i_rsp_ack    = 2'b11;
        #1;
        checks++;
        if (o_rsp_valid !== 2'b00 || o_mem_ack !== 1'b1) begin
            fails++;
            $display("FAIL spur_drop: valid=%b mack=%b, required 00 and 1", o_rsp_valid, o_mem_ack);
        end
        step();
        idle();
        step();
        step();
        checks++;
        if (o_spurious !== 1'b1) begin
            fails++;
            $display("FAIL spur_sticky: spur=%b, required 1", o_spurious);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rr_fill();
        test_full_pop();
        test_response();
        test_id_exhaust();
        test_write_pop();
        test_spurious();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
